// File: rtl/gpu_mmio_regs.sv
// CPU-bus register window for the GraphicSystem: parameter registers, draw/clear
// command sequencing against GPU busy, and vsync-aligned buffer swaps.
module gpu_mmio_regs #(
    parameter logic [31:0] BASE        = 32'h0000_6000,
    parameter int unsigned BUSY_LAT    = 2,
    parameter logic [15:0] CLEAR_RESET = 16'hD8B7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] gpu_CtrlAddress,
    output logic [15:0] gpu_CtrlAddressX,
    output logic [15:0] gpu_CtrlAddressY,
    output logic [15:0] gpu_CtrlImageWidth,
    output logic [10:0] gpu_CtrlWidth,
    output logic [9:0]  gpu_CtrlHeight,
    output logic [10:0] gpu_CtrlX,
    output logic [9:0]  gpu_CtrlY,
    output logic [15:0] gpu_CtrlClearColor,
    output logic        gpu_CtrlDraw,
    output logic        gpu_CtrlClear,
    input  logic        gpu_CtrlBusy,
    output logic        swapBuffers,
    output logic        isVSynced,
    input  logic        hdmi_vSync
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned OFF_W  = 9;
    localparam logic [31:0] WIN_SZ = 32'h0000_0200;

    localparam logic [OFF_W-1:0] OFF_ADDR     = 9'h000;
    localparam logic [OFF_W-1:0] OFF_ADDR_X   = 9'h004;
    localparam logic [OFF_W-1:0] OFF_ADDR_Y   = 9'h008;
    localparam logic [OFF_W-1:0] OFF_IMG_W    = 9'h00C;
    localparam logic [OFF_W-1:0] OFF_WIDTH    = 9'h010;
    localparam logic [OFF_W-1:0] OFF_HEIGHT   = 9'h014;
    localparam logic [OFF_W-1:0] OFF_X        = 9'h018;
    localparam logic [OFF_W-1:0] OFF_Y        = 9'h01C;
    localparam logic [OFF_W-1:0] OFF_DRAW     = 9'h020;
    localparam logic [OFF_W-1:0] OFF_CLR_COL  = 9'h024;
    localparam logic [OFF_W-1:0] OFF_CLEAR    = 9'h028;
    localparam logic [OFF_W-1:0] OFF_STATUS   = 9'h02C;
    localparam logic [OFF_W-1:0] OFF_SWAP     = 9'h100;
    localparam logic [OFF_W-1:0] OFF_VSYNC    = 9'h108;
    localparam logic [OFF_W-1:0] OFF_VSYNC_EN = 9'h10C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    logic        ready_q;
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic [15:0] addr_x_q, addr_y_q, img_w_q, clr_col_q;
    logic [10:0] width_q, x_q;
    logic [9:0]  height_q, y_q;
    logic        vsync_en_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             draw_q, draw_d, clear_q, clear_d, swap_q, swap_d;
    logic             draw_pend_q, draw_pend_d;
    logic             clear_pend_q, clear_pend_d;
    logic             swap_pend_q, swap_pend_d;
    logic             frame_q, frame_d;
    logic             vs_prev_q;

    logic [31:0]      off_c;
    logic [OFF_W-1:0] woff_c;
    logic             hit_c, wr_c, rd_c;
    logic             set_draw_c, set_clear_c, set_swap_c, rd_vsync_c, vs_rise_c;
    logic [31:0]      rdata_c;

    // Window decode; the unsigned subtraction wraps addresses below BASE out of range.
    // A request is not re-accepted in its acknowledge cycle.
    assign off_c  = mem_addr - BASE;
    assign woff_c = off_c[OFF_W-1:0];
    assign hit_c  = mem_valid && (off_c < WIN_SZ) && !ready_q;
    assign wr_c   = hit_c && (mem_wstrb == 4'hF);
    assign rd_c   = hit_c && (mem_wstrb == 4'h0);

    assign set_draw_c  = wr_c && (woff_c == OFF_DRAW)  && mem_wdata[0];
    assign set_clear_c = wr_c && (woff_c == OFF_CLEAR) && mem_wdata[0];
    assign set_swap_c  = wr_c && (woff_c == OFF_SWAP)  && mem_wdata[0];
    assign rd_vsync_c  = rd_c && (woff_c == OFF_VSYNC);
    assign vs_rise_c   = hdmi_vSync && !vs_prev_q;

    // Read mux, sampled in the request cycle
    always_comb begin
        rdata_c = '0;
        case (woff_c)
            OFF_ADDR:     rdata_c = addr_q;
            OFF_ADDR_X:   rdata_c = 32'(addr_x_q);
            OFF_ADDR_Y:   rdata_c = 32'(addr_y_q);
            OFF_IMG_W:    rdata_c = 32'(img_w_q);
            OFF_WIDTH:    rdata_c = 32'(width_q);
            OFF_HEIGHT:   rdata_c = 32'(height_q);
            OFF_X:        rdata_c = 32'(x_q);
            OFF_Y:        rdata_c = 32'(y_q);
            OFF_CLR_COL:  rdata_c = 32'(clr_col_q);
            OFF_STATUS:   rdata_c = {28'b0, swap_pend_q, clear_pend_q, draw_pend_q, gpu_CtrlBusy};
            OFF_VSYNC:    rdata_c = {30'b0, frame_q, hdmi_vSync};
            OFF_VSYNC_EN: rdata_c = 32'(vsync_en_q);
            default:      rdata_c = '0;
        endcase
    end

    // Bus acknowledge and read data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= hit_c;
            rdata_q <= hit_c ? rdata_c : '0;
        end
    end

    // Parameter registers; full-word writes only, truncated to register width
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            addr_x_q   <= '0;
            addr_y_q   <= '0;
            img_w_q    <= '0;
            width_q    <= '0;
            height_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            clr_col_q  <= CLEAR_RESET;
            vsync_en_q <= 1'b1;
        end else if (wr_c) begin
            case (woff_c)
                OFF_ADDR:     addr_q     <= mem_wdata;
                OFF_ADDR_X:   addr_x_q   <= mem_wdata[15:0];
                OFF_ADDR_Y:   addr_y_q   <= mem_wdata[15:0];
                OFF_IMG_W:    img_w_q    <= mem_wdata[15:0];
                OFF_WIDTH:    width_q    <= mem_wdata[10:0];
                OFF_HEIGHT:   height_q   <= mem_wdata[9:0];
                OFF_X:        x_q        <= mem_wdata[10:0];
                OFF_Y:        y_q        <= mem_wdata[9:0];
                OFF_CLR_COL:  clr_col_q  <= mem_wdata[15:0];
                OFF_VSYNC_EN: vsync_en_q <= mem_wdata[0];
                default:      ;
            endcase
        end
    end

    // Draw/clear sequencer; a write landing on a bit being consumed coalesces into it
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        draw_d       = 1'b0;
        clear_d      = 1'b0;
        draw_pend_d  = draw_pend_q | set_draw_c;
        clear_pend_d = clear_pend_q | set_clear_c;
        case (state_q)
            ST_IDLE: begin
                if (!gpu_CtrlBusy && (clear_pend_q || draw_pend_q)) begin
                    if (clear_pend_q) begin
                        clear_d      = 1'b1;
                        clear_pend_d = 1'b0;
                    end else begin
                        draw_d      = 1'b1;
                        draw_pend_d = 1'b0;
                    end
                    cnt_d   = CNT_W'(BUSY_LAT);
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!gpu_CtrlBusy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Swap path and sticky frame flag; a vsync edge beats a same-cycle clear-on-read
    always_comb begin
        swap_d      = swap_pend_q && (!vsync_en_q || vs_rise_c);
        swap_pend_d = swap_d ? 1'b0 : (swap_pend_q | set_swap_c);
        frame_d     = frame_q;
        if (rd_vsync_c) begin
            frame_d = 1'b0;
        end
        if (vs_rise_c) begin
            frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            draw_q       <= 1'b0;
            clear_q      <= 1'b0;
            swap_q       <= 1'b0;
            draw_pend_q  <= 1'b0;
            clear_pend_q <= 1'b0;
            swap_pend_q  <= 1'b0;
            frame_q      <= 1'b0;
            vs_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            draw_q       <= draw_d;
            clear_q      <= clear_d;
            swap_q       <= swap_d;
            draw_pend_q  <= draw_pend_d;
            clear_pend_q <= clear_pend_d;
            swap_pend_q  <= swap_pend_d;
            frame_q      <= frame_d;
            vs_prev_q    <= hdmi_vSync;
        end
    end

    assign mem_ready          = ready_q;
    assign mem_rdata          = rdata_q;
    assign gpu_CtrlAddress    = addr_q;
    assign gpu_CtrlAddressX   = addr_x_q;
    assign gpu_CtrlAddressY   = addr_y_q;
    assign gpu_CtrlImageWidth = img_w_q;
    assign gpu_CtrlWidth      = width_q;
    assign gpu_CtrlHeight     = height_q;
    assign gpu_CtrlX          = x_q;
    assign gpu_CtrlY          = y_q;
    assign gpu_CtrlClearColor = clr_col_q;
    assign gpu_CtrlDraw       = draw_q;
    assign gpu_CtrlClear      = clear_q;
    assign swapBuffers        = swap_q;
    assign isVSynced          = vsync_en_q;

endmodule

// File: tb/tb_gpu_mmio_regs.sv
// Directed bench for gpu_mmio_regs: register access, command ordering, swap and reset.
module tb_gpu_mmio_regs;

    localparam logic [31:0] BASE = 32'h0000_6000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] gpu_CtrlAddress;
    logic [15:0] gpu_CtrlAddressX, gpu_CtrlAddressY, gpu_CtrlImageWidth, gpu_CtrlClearColor;
    logic [10:0] gpu_CtrlWidth, gpu_CtrlX;
    logic [9:0]  gpu_CtrlHeight, gpu_CtrlY;
    logic        gpu_CtrlDraw, gpu_CtrlClear, gpu_CtrlBusy;
    logic        swapBuffers, isVSynced, hdmi_vSync;

    logic        tb_busy;
    logic        model_en;
    int          model_cnt = 0;
    int          cyc = 0;
    int          n_draw = 0, n_clear = 0, n_swap = 0;
    int          t_draw = 0, t_clear = 0;
    int          total = 0, bad = 0;

    assign gpu_CtrlBusy = tb_busy || (model_cnt != 0);

    gpu_mmio_regs #(.BASE(BASE), .BUSY_LAT(2), .CLEAR_RESET(16'hD8B7)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .gpu_CtrlAddress(gpu_CtrlAddress), .gpu_CtrlAddressX(gpu_CtrlAddressX),
        .gpu_CtrlAddressY(gpu_CtrlAddressY), .gpu_CtrlImageWidth(gpu_CtrlImageWidth),
        .gpu_CtrlWidth(gpu_CtrlWidth), .gpu_CtrlHeight(gpu_CtrlHeight),
        .gpu_CtrlX(gpu_CtrlX), .gpu_CtrlY(gpu_CtrlY), .gpu_CtrlClearColor(gpu_CtrlClearColor),
        .gpu_CtrlDraw(gpu_CtrlDraw), .gpu_CtrlClear(gpu_CtrlClear), .gpu_CtrlBusy(gpu_CtrlBusy),
        .swapBuffers(swapBuffers), .isVSynced(isVSynced), .hdmi_vSync(hdmi_vSync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (gpu_CtrlDraw)  begin n_draw++;  t_draw  = cyc; end
        if (gpu_CtrlClear) begin n_clear++; t_clear = cyc; end
        if (swapBuffers)   n_swap++;
    end

    // GPU model: busy for 20 cycles after each command pulse
    always @(negedge clk) begin
        if (model_en && (gpu_CtrlClear || gpu_CtrlDraw)) model_cnt <= 20;
        else if (model_cnt != 0) model_cnt <= model_cnt - 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns at #1 after the edge that raises mem_ready
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r);
        int n;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        @(posedge clk); #1;
        n = 0;
        while (!mem_ready && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        if (!mem_ready) check("bus_timeout", 32'(mem_ready), 32'd1);
        r = mem_rdata;
        mem_valid = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] r;
        bus(BASE + off, d, 4'hF, r);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] r);
        bus(BASE + off, 32'h0, 4'h0, r);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [31:0] r;
        int s0, d0, c0, nr;

        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        tb_busy = 1'b0; model_en = 1'b0; hdmi_vSync = 1'b0;
        #12;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_clrcol", 32'(gpu_CtrlClearColor), 32'hD8B7);
        check("rst_isvsync", 32'(isVSynced), 32'd1);
        check("rst_addr", gpu_CtrlAddress, 32'd0);
        check("rst_pulses", {29'b0, gpu_CtrlDraw, gpu_CtrlClear, swapBuffers}, 32'd0);
        @(negedge clk); resetn = 1'b1;
        cycles(2);

        // Register readback and one-cycle acknowledge
        wr(32'h00, 32'h1234_5678);
        check("addr_out", gpu_CtrlAddress, 32'h1234_5678);
        wr(32'h10, 32'h0000_FFFF);
        check("width_out", 32'(gpu_CtrlWidth), 32'h7FF);
        wr(32'h08, 32'hABCD_EF01);
        check("addry_out", 32'(gpu_CtrlAddressY), 32'hEF01);
        wr(32'h14, 32'hFFFF_FFFF);
        check("height_out", 32'(gpu_CtrlHeight), 32'h3FF);
        rd(32'h00, r);
        check("rd_addr", r, 32'h1234_5678);
        check("ready_hi", 32'(mem_ready), 32'd1);
        cycles(1);
        check("ready_once", 32'(mem_ready), 32'd0);
        rd(32'h10, r);
        check("rd_width", r, 32'h7FF);
        rd(32'h20, r);
        check("rd_draw_zero", r, 32'd0);

        // Partial write discarded; out-of-window access never acknowledged
        wr(32'h24, 32'h0);
        bus(BASE + 32'h24, 32'h0000_AAAA, 4'b0011, r);
        rd(32'h24, r);
        check("rd_clrcol_zero", r, 32'h0);
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        bus(BASE + 32'h24, 32'h0000_AAAA, 4'b0011, r);
        rd(32'h24, r);
        check("partial_ignored", r, 32'hD8B7);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = BASE + 32'h200; mem_wstrb = 4'hF; mem_wdata = 32'h5;
        nr = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (mem_ready) nr++; end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        check("outside_no_ready", 32'(nr), 32'd0);

        // Draw in idle: pulse two cycles after the request
        wr(32'h20, 32'h1);
        check("draw_n1", 32'(gpu_CtrlDraw), 32'd0);
        cycles(1);
        check("draw_n2", 32'(gpu_CtrlDraw), 32'd1);
        cycles(1);
        check("draw_n3", 32'(gpu_CtrlDraw), 32'd0);
        cycles(6);

        // Draw while busy
        tb_busy = 1'b1;
        d0 = n_draw;
        wr(32'h20, 32'h1);
        cycles(5);
        check("busy_no_draw", 32'(n_draw - d0), 32'd0);
        rd(32'h2C, r);
        check("status_busy", r, 32'h3);
        @(negedge clk); tb_busy = 1'b0;
        cycles(4);
        check("draw_after_busy", 32'(n_draw - d0), 32'd1);
        rd(32'h2C, r);
        check("status_idle", r, 32'h0);
        cycles(6);

        // Clear before draw, minimum spacing with busy never rising
        tb_busy = 1'b1;
        c0 = n_clear; d0 = n_draw;
        wr(32'h28, 32'h1);
        wr(32'h20, 32'h1);
        rd(32'h2C, r);
        check("status_both", r, 32'h7);
        @(negedge clk); tb_busy = 1'b0;
        cycles(12);
        check("order_clear_n", 32'(n_clear - c0), 32'd1);
        check("order_draw_n", 32'(n_draw - d0), 32'd1);
        check("order_gap_min", 32'(t_draw - t_clear), 32'd4);

        // Clear then draw with the GPU model holding busy for 20 cycles
        tb_busy = 1'b1; model_en = 1'b1;
        c0 = n_clear; d0 = n_draw;
        wr(32'h28, 32'h1);
        wr(32'h20, 32'h1);
        @(negedge clk); tb_busy = 1'b0;
        cycles(40);
        check("gpu_clear_n", 32'(n_clear - c0), 32'd1);
        check("gpu_draw_n", 32'(n_draw - d0), 32'd1);
        check("gpu_gap", 32'(t_draw - t_clear), 32'd22);
        model_en = 1'b0;
        cycles(25);

        // Swap on vsync, two requests coalesce
        s0 = n_swap;
        wr(32'h100, 32'h1);
        wr(32'h100, 32'h1);
        cycles(5);
        check("swap_wait_vs", 32'(n_swap - s0), 32'd0);
        hdmi_vSync = 1'b1;
        check("swap_rise_cyc", 32'(swapBuffers), 32'd0);
        cycles(1);
        check("swap_after_rise", 32'(swapBuffers), 32'd1);
        cycles(1);
        check("swap_one_cyc", 32'(swapBuffers), 32'd0);
        cycles(5);
        check("swap_count", 32'(n_swap - s0), 32'd1);
        rd(32'h108, r);
        check("vsync_flag", r, 32'h3);
        rd(32'h108, r);
        check("vsync_flag_clr", r, 32'h1);
        @(negedge clk); hdmi_vSync = 1'b0;
        rd(32'h108, r);
        check("vsync_low", r, 32'h0);

        // Swap without vsync alignment
        wr(32'h10C, 32'h0);
        check("isvsync_off", 32'(isVSynced), 32'd0);
        wr(32'h100, 32'h1);
        check("swap_nv_n1", 32'(swapBuffers), 32'd0);
        cycles(1);
        check("swap_nv_n2", 32'(swapBuffers), 32'd1);
        wr(32'h10C, 32'h1);

        // Asynchronous reset mid-command
        wr(32'h24, 32'h1111);
        check("clrcol_out", 32'(gpu_CtrlClearColor), 32'h1111);
        tb_busy = 1'b1;
        wr(32'h20, 32'h1);
        wr(32'h100, 32'h1);
        rd(32'h2C, r);
        check("status_pend", r, 32'hB);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("mid_rst_addr", gpu_CtrlAddress, 32'd0);
        check("mid_rst_clrcol", 32'(gpu_CtrlClearColor), 32'hD8B7);
        check("mid_rst_ready", 32'(mem_ready), 32'd0);
        d0 = n_draw; s0 = n_swap;
        @(negedge clk); resetn = 1'b1; tb_busy = 1'b0;
        cycles(3);
        hdmi_vSync = 1'b1;
        cycles(6);
        check("post_rst_draw", 32'(n_draw - d0), 32'd0);
        check("post_rst_swap", 32'(n_swap - s0), 32'd0);
        rd(32'h2C, r);
        check("post_rst_status", r, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpu_mmio_regs.md
# gpu_mmio_regs

Memory-mapped register responder that connects the picorv32 native memory bus to the GraphicSystem control inputs. It decodes a fixed address window and holds the GPU blit/clear parameters. It sequences draw, clear and buffer-swap commands against GPU busy and HDMI vertical sync, and returns status to the CPU. It sits beside the RAM responder on the CPU bus and replaces ad-hoc register decoding.

## Interface
- `BASE`, default 32'h0000_6000: byte address of the register window; the window spans BASE..BASE+0x1FF.
- `BUSY_LAT`, default 2: guard cycles after a draw/clear pulse before `gpu_CtrlBusy` is sampled.
- `CLEAR_RESET`, default 16'hD8B7: reset value of the clear colour.
- `clk` in 1: single clock; CPU, GPU control and vsync input are all synchronous to it.
- `resetn` in 1: asynchronous, active-low reset.
- `mem_valid` in 1: CPU request valid, held until `mem_ready`.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte strobes; 0 means read.
- `mem_ready` out 1: one-cycle acknowledge.
- `mem_rdata` out 32: read data, valid with `mem_ready`.
- `gpu_CtrlAddress` out 32, `gpu_CtrlAddressX` out 16, `gpu_CtrlAddressY` out 16, `gpu_CtrlImageWidth` out 16, `gpu_CtrlWidth` out 11, `gpu_CtrlHeight` out 10, `gpu_CtrlX` out 11, `gpu_CtrlY` out 10, `gpu_CtrlClearColor` out 16: parameter registers.
- `gpu_CtrlDraw` out 1: one-cycle draw start pulse.
- `gpu_CtrlClear` out 1: one-cycle clear start pulse.
- `gpu_CtrlBusy` in 1: GPU busy.
- `swapBuffers` out 1: one-cycle swap pulse.
- `isVSynced` out 1: swap-on-vsync enable.
- `hdmi_vSync` in 1: vertical sync level.

## Operation
- **Decode.** A request hits when `mem_valid` is high and `mem_addr` is within BASE..BASE+0x1FF. Requests outside the window are ignored entirely: no `mem_ready`.
- **Write rule.** Only full-word writes (`mem_wstrb`==4'hF) take effect. Partial writes are acknowledged and discarded. Values are truncated to register width.
- **Register offsets (R = read, W = write).**
  - 0x00 ADDR, RW.
  - 0x04 ADDR_X, RW.
  - 0x08 ADDR_Y, RW.
  - 0x0C IMG_W, RW.
  - 0x10 WIDTH, RW.
  - 0x14 HEIGHT, RW.
  - 0x18 X, RW.
  - 0x1C Y, RW.
  - 0x20 DRAW: W bit0=1 sets draw_pend; reads 0.
  - 0x24 CLEAR_COLOR, RW.
  - 0x28 CLEAR: W bit0=1 sets clear_pend; reads 0.
  - 0x2C STATUS, R: {28'b0, swap_pend, clear_pend, draw_pend, gpu_CtrlBusy}.
  - 0x100 SWAP: W bit0=1 sets swap_pend; reads 0.
  - 0x108 VSYNC, R: {30'b0, frame_flag, hdmi_vSync}. Reading clears frame_flag.
  - 0x10C VSYNC_EN, RW bit0 → `isVSynced`.
  - Any other offset: reads 0, writes ignored.
  - Read data is zero-extended.
- **Command sequencer.** FSM with states IDLE, GUARD, WAIT.
  - IDLE: if any pend bit is set and `gpu_CtrlBusy`=0, pulse the command for one cycle and clear its pend bit. Clear has priority over draw. Then go to GUARD with the counter loaded to BUSY_LAT.
  - GUARD: decrement the counter; at 0 go to WAIT.
  - WAIT: when `gpu_CtrlBusy`=0, go to IDLE.
  - Setting an already-set pend bit has no additional effect (requests coalesce).
- **Swap.**
  - With swap_pend set and `isVSynced`=0: pulse `swapBuffers` on the next cycle.
  - With `isVSynced`=1: pulse on the cycle after a rising edge of `hdmi_vSync`, detected from a registered previous value.
  - The pulse clears swap_pend.
  - The swap path is independent of the draw/clear FSM.
- **Frame flag.** frame_flag is a sticky bit, set on every `hdmi_vSync` rising edge. If a set and a clear-on-read occur in the same cycle, set wins.
- **Parameter writes.** Accepted at any time, including while the GPU is busy; the outputs update immediately.

## Timing
- Request in cycle N → `mem_ready`=1 and `mem_rdata` valid in N+1, high for exactly one cycle.
- A `mem_valid` still high in N+1 is not re-accepted. The next acceptance is possible at N+2 at the earliest.
- Register write visible on its output in N+1.
- DRAW/CLEAR write in N with the FSM in IDLE and busy=0: pulse in N+2.
- With both pend bits set: clear is pulsed first. Draw follows at the earliest BUSY_LAT+2 cycles later, after busy has dropped.
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0.
  - All parameter registers 0, except `gpu_CtrlClearColor`=CLEAR_RESET and `isVSynced`=1.
  - All pulses 0, all pend bits 0, frame_flag 0, FSM in IDLE.
- Reset mid-command drops all pending requests immediately; the previous-vsync register resets to 0.

## Test plan
- **Register readback:** write 0x1234_5678 to 0x00 and 0xFFFF to 0x10, then read both → 0x1234_5678 and 0x7FF; `mem_ready` is high for exactly one cycle per access.
- **Partial write ignored:** write 0xAAAA to 0x24 with strobe 4'b0011, then read 0x24 → 0xD8B7. An access at BASE+0x200 → no `mem_ready` for 10 cycles.
- **Draw while busy:** hold busy=1 and write DRAW=1 → no pulse, STATUS=0x3. Drop busy → single `gpu_CtrlDraw` pulse two cycles later, STATUS=0x0.
- **Clear/draw ordering:** write CLEAR, then DRAW back-to-back while busy=1. Release busy → clear pulse; GPU model raises busy for 20 cycles; then draw pulse after busy falls.
- **Vsync swap:**
  - isVSynced=1: write SWAP → no pulse until the `hdmi_vSync` rise, then one pulse on the following cycle.
  - isVSynced=0: write SWAP → pulse two cycles after the write.
  - Two SWAP writes before vsync → exactly one pulse.
- **Reset mid-operation:** set draw/swap pend, assert `resetn`=0 asynchronously mid-cycle → all outputs reach reset values immediately; no pulses after release.
